// File: rtl/spi_link_pkg.sv
// spi_link_pkg: link geometry and receiver state shared by both ends of the 4-line pixel link
package spi_link_pkg;
  localparam int LINK_LINES       = 4;
  localparam int LINK_DATA_WIDTH  = 8;
  localparam int FRAME_H          = 320;
  localparam int FRAME_V          = 180;
  localparam int LINK_SYNC_STAGES = 2;
  typedef enum logic [1:0] {WAIT_FRAME, IDLE, RECV} rx_state_e;
endpackage

// File: rtl/link_input_sync.sv
// link_input_sync: synchronizer bank for the link pins plus a registered dclk rising-edge strobe.
module link_input_sync
  import spi_link_pkg::*;
#(
  parameter int LINES       = LINK_LINES,
  parameter int SYNC_STAGES = LINK_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             dclk_i,
  input  logic [LINES-1:0] cipo_i,
  input  logic             cs_i,
  input  logic             tlast_i,
  output logic [LINES-1:0] cipo_o,
  output logic             cs_o,
  output logic             tlast_o,
  output logic             capture_strobe_o
);
  localparam int W = LINES + 3;
  // Pins packed as {dclk, cs, tlast, cipo}; reset looks like an idle link with cs deasserted
  localparam logic [W-1:0] IDLE_PINS = W'(1) << (LINES + 1);
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] pins_s;
  logic         dclk_prev_q;
  assign pins_s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_PINS;
      dclk_prev_q                <= 1'b0;
      capture_strobe_o           <= 1'b0;
      {cs_o, tlast_o, cipo_o}    <= IDLE_PINS[W-2:0];
    end else begin
      sync_q[0] <= {dclk_i, cs_i, tlast_i, cipo_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dclk_prev_q             <= pins_s[W-1];
      capture_strobe_o        <= pins_s[W-1] & ~dclk_prev_q;
      {cs_o, tlast_o, cipo_o} <= pins_s[W-2:0];
    end
  end
endmodule

// File: rtl/spi_receive_con.sv
// spi_receive_con: oversampling receiver for the 4-line pixel link.
// Rebuilds pixels from nibbles, tags them with frame position and tracks frame alignment.
module spi_receive_con
  import spi_link_pkg::*;
#(
  parameter int DATA_WIDTH  = LINK_DATA_WIDTH,
  parameter int LINES       = LINK_LINES,
  parameter int HPIXELS     = FRAME_H,
  parameter int VPIXELS     = FRAME_V,
  parameter int SYNC_STAGES = LINK_SYNC_STAGES
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  dclk_in,
  input  logic [LINES-1:0]      cipo_in,
  input  logic                  cs_in,
  input  logic                  tlast_in,
  output logic [DATA_WIDTH-1:0] pixel_data_out,
  output logic                  pixel_valid_out,
  output logic [8:0]            hcount_out,
  output logic [7:0]            vcount_out,
  output logic                  frame_done_out,
  output logic                  synced_out,
  output logic [7:0]            err_count_out
);
  localparam int NIB = DATA_WIDTH / LINES;
  localparam int NW  = NIB > 1 ? $clog2(NIB) : 1;
  localparam logic [NW-1:0] NIB_LAST = NW'(NIB - 1);
  localparam logic [8:0]    H_LAST   = 9'(HPIXELS - 1);
  localparam logic [7:0]    V_LAST   = 8'(VPIXELS - 1);

  logic [LINES-1:0] cipo_s;
  logic             cs_s, tlast_s, cap;

  link_input_sync #(.LINES(LINES), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i            (clk_in),
    .rst_n_i          (rst_n_in),
    .dclk_i           (dclk_in),
    .cipo_i           (cipo_in),
    .cs_i             (cs_in),
    .tlast_i          (tlast_in),
    .cipo_o           (cipo_s),
    .cs_o             (cs_s),
    .tlast_o          (tlast_s),
    .capture_strobe_o (cap)
  );

  rx_state_e             st_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [NW-1:0]         nib_q;
  logic [8:0]            h_q;
  logic [7:0]            v_q, err_d;
  logic                  last_nib, at_end;

  assign shift_d  = DATA_WIDTH'({shift_q, cipo_s});
  assign last_nib = cap && nib_q == NIB_LAST;
  assign at_end   = h_q == H_LAST && v_q == V_LAST;
  assign err_d    = err_count_out + {7'd0, err_count_out != 8'hFF};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st_q            <= WAIT_FRAME;
      shift_q         <= '0;
      nib_q           <= '0;
      h_q             <= '0;
      v_q             <= '0;
      pixel_data_out  <= '0;
      pixel_valid_out <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_done_out  <= 1'b0;
      synced_out      <= 1'b0;
      err_count_out   <= '0;
    end else begin
      pixel_valid_out <= 1'b0;
      frame_done_out  <= 1'b0;
      case (st_q)
        WAIT_FRAME: begin
          if (cs_s) nib_q <= '0;
          else if (cap) begin
            shift_q <= shift_d;
            nib_q   <= last_nib ? '0 : nib_q + NW'(1);
            if (last_nib && tlast_s) begin
              st_q       <= IDLE;
              synced_out <= 1'b1;
              h_q        <= '0;
              v_q        <= '0;
            end
          end
        end
        default: begin
          if (cs_s) begin
            // A pixel cut short by cs is dropped and counted as a link error
            if (st_q == RECV && nib_q != '0) err_count_out <= err_d;
            nib_q <= '0;
            st_q  <= IDLE;
          end else begin
            st_q <= RECV;
            if (cap) begin
              shift_q <= shift_d;
              nib_q   <= last_nib ? '0 : nib_q + NW'(1);
              if (last_nib) begin
                pixel_data_out  <= shift_d;
                pixel_valid_out <= 1'b1;
                hcount_out      <= h_q;
                vcount_out      <= v_q;
                if (tlast_s) begin
                  frame_done_out <= 1'b1;
                  h_q            <= '0;
                  v_q            <= '0;
                  if (!at_end) err_count_out <= err_d;
                end else if (h_q == H_LAST) begin
                  h_q <= '0;
                  if (v_q == V_LAST) begin
                    // Frame overran without tlast: drop alignment and hunt for the next frame end
                    err_count_out <= err_d;
                    synced_out    <= 1'b0;
                    st_q          <= WAIT_FRAME;
                    v_q           <= '0;
                  end else v_q <= v_q + 8'd1;
                end else h_q <= h_q + 9'd1;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_receive_con.sv
// tb_spi_receive_con: drives the pixel link and scores received pixels against a per-pixel frame model.
module tb_spi_receive_con;
  localparam int H = 16, V = 6, DW = 8, LN = 4;

  logic          clk = 0, rst_n = 0, dclk = 0, cs = 1, tlast = 0;
  logic [LN-1:0] cipo = '0;
  logic [DW-1:0] pixel_data;
  logic          pixel_valid, frame_done, synced;
  logic [8:0]    hcount;
  logic [7:0]    vcount, err_count;

  spi_receive_con #(.DATA_WIDTH(DW), .LINES(LN), .HPIXELS(H), .VPIXELS(V), .SYNC_STAGES(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .dclk_in(dclk), .cipo_in(cipo), .cs_in(cs), .tlast_in(tlast),
    .pixel_data_out(pixel_data), .pixel_valid_out(pixel_valid), .hcount_out(hcount),
    .vcount_out(vcount), .frame_done_out(frame_done), .synced_out(synced), .err_count_out(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; int h; int v; bit done; } px_t;
  typedef struct { bit abort; logic [7:0] d; bit tl; int eh; int ev; bit edone; int eerr; } vec_t;

  px_t exp_q[$];
  px_t last_px;
  int  n_cmp = 0, n_err = 0, n_valid = 0, cyc = 0, rise_cyc = 0, valid_cyc = 0;
  bit  m_sync = 0;
  int  m_h = 0, m_v = 0, m_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void bump_err();
    m_err = m_err < 255 ? m_err + 1 : 255;
  endfunction

  // Frame model: position is a linear pixel index within an H*V frame
  function automatic void model_pixel(input logic [7:0] d, input bit tl);
    int idx;
    if (!m_sync) begin
      if (tl) begin m_sync = 1; m_h = 0; m_v = 0; end
      return;
    end
    exp_q.push_back('{d, m_h, m_v, tl});
    if (tl) begin
      if (m_h != H - 1 || m_v != V - 1) bump_err();
      m_h = 0; m_v = 0;
    end else begin
      idx = m_v * H + m_h + 1;
      if (idx == H * V) begin bump_err(); m_sync = 0; m_h = 0; m_v = 0; end
      else begin m_h = idx % H; m_v = idx / H; end
    end
  endfunction

  always @(posedge clk) begin
    px_t e;
    cyc++;
    #1;
    chk("done_without_valid", {31'd0, frame_done & ~pixel_valid}, 0);
    if (pixel_valid) begin
      n_valid++;
      valid_cyc  = cyc;
      last_px.d  = pixel_data;
      last_px.h  = int'(hcount);
      last_px.v  = int'(vcount);
      last_px.done = frame_done;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_valid: got pixel %0h at (%0d,%0d), required no pixel", pixel_data, hcount, vcount);
      end else begin
        e = exp_q.pop_front();
        chk("pix_data", pixel_data, e.d);
        chk("pix_h", hcount, e.h);
        chk("pix_v", vcount, e.v);
        chk("pix_done", frame_done, e.done);
      end
    end
  end

  task automatic send_nib(input logic [3:0] n, input bit tl, input int half);
    @(negedge clk);
    cipo = n; tlast = tl; cs = 0; dclk = 0;
    repeat (half) @(negedge clk);
    dclk = 1; rise_cyc = cyc;
    repeat (half) @(negedge clk);
    dclk = 0;
  endtask

  task automatic send_pixel(input logic [7:0] d, input bit tl, input int half);
    model_pixel(d, tl);
    send_nib(d[7:4], 1'b0, half);
    send_nib(d[3:0], tl, half);
  endtask

  task automatic do_abort();
    if (m_sync) bump_err();
    send_nib(4'($urandom), 1'b0, 2);
    @(negedge clk); cs = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic gap();
    @(negedge clk); cs = 1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, pixel_data, 0);
    chk({tag, "_valid"}, pixel_valid, 0);
    chk({tag, "_h"}, hcount, 0);
    chk({tag, "_v"}, vcount, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_synced"}, synced, 0);
    chk({tag, "_err"}, err_count, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, required finish before 900us");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[5];
    int base, r;
    tbl[0] = '{1'b1, 8'h3C, 1'b0, 1, 0, 1'b0, 1};
    tbl[1] = '{1'b0, 8'h11, 1'b0, 2, 0, 1'b0, 1};
    tbl[2] = '{1'b0, 8'h22, 1'b1, 3, 0, 1'b1, 2};
    tbl[3] = '{1'b0, 8'h33, 1'b0, 0, 0, 1'b0, 2};
    tbl[4] = '{1'b1, 8'h44, 1'b0, 1, 0, 1'b0, 3};

    #23;
    chk_zero("reset");
    @(negedge clk); rst_n = 1;
    repeat (5) @(negedge clk);

    // Alignment frame: nothing is emitted until the first tlast pixel
    repeat (3) send_pixel(8'($urandom), 1'b0, 2);
    send_pixel(8'h77, 1'b1, 2);
    drain();
    chk("align_synced", synced, 1);
    chk("align_valids", n_valid, 0);

    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++)
        send_pixel(8'((h + v) % 256), h == H - 1 && v == V - 1, 2);
    drain();
    chk("frame_valids", n_valid, H * V);
    chk("frame_err", err_count, 0);

    send_pixel(8'hA5, 1'b0, 3);
    drain();
    chk("lat_data", last_px.d, 8'hA5);
    chk("latency", valid_cyc - rise_cyc, 4);

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].abort) do_abort();
      send_pixel(tbl[i].d, tbl[i].tl, 2);
      drain();
      chk("tbl_data", last_px.d, tbl[i].d);
      chk("tbl_h", last_px.h, tbl[i].eh);
      chk("tbl_v", last_px.v, tbl[i].ev);
      chk("tbl_done", last_px.done, tbl[i].edone);
      chk("tbl_err", err_count, tbl[i].eerr);
    end

    // Overrun: a frame's worth of pixels with no tlast, then re-alignment
    base = n_valid;
    repeat (H * V) send_pixel(8'($urandom), 1'b0, 2);
    drain();
    chk("ovr_synced", synced, 0);
    chk("ovr_err", err_count, 4);
    chk("ovr_valids", n_valid - base, H * V - 2);
    base = n_valid;
    repeat (3) send_pixel(8'($urandom), 1'b0, 2);
    send_pixel(8'h5A, 1'b1, 2);
    drain();
    chk("realign_valids", n_valid - base, 0);
    chk("realign_synced", synced, 1);

    repeat (150) begin
      r = $urandom_range(0, 99);
      if (r < 8) do_abort();
      else if (r < 14) gap();
      send_pixel(8'($urandom), $urandom_range(0, 24) == 0, $urandom_range(2, 4));
    end
    drain();
    chk("rand_err", err_count, m_err);
    chk("rand_synced", synced, m_sync);

    send_pixel(8'h01, 1'b1, 2);
    repeat (260) do_abort();
    drain();
    chk("err_saturate", err_count, 255);

    // Asynchronous reset in the middle of a pixel
    send_nib(4'h9, 1'b0, 2);
    @(posedge clk); #3 rst_n = 0; cs = 1;
    #1 chk_zero("async_rst");
    m_sync = 0; m_h = 0; m_v = 0; m_err = 0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1;
    repeat (4) @(negedge clk);
    chk("post_rst_synced", synced, 0);
    base = n_valid;
    repeat (3) send_pixel(8'($urandom), 1'b0, 2);
    send_pixel(8'hEE, 1'b1, 2);
    send_pixel(8'h12, 1'b0, 2);
    send_pixel(8'h34, 1'b0, 2);
    drain();
    chk("post_rst_valids", n_valid - base, 2);
    chk("post_rst_h", last_px.h, 1);
    chk("post_rst_resync", synced, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
